store_row_drainer: RTL and testbench

Parametrised store path that replaces the fixed four-core store controller and register pair. It holds one NCORE-lane row buffer per register row. Each core writes its own lane. When every enabled core requests a store, the block drains rows 0..last_row to data memory, one full-width row per beat, over a valid/ready handshake. It sits between the core store ports and the data-memory write port.

---
 rtl/store_row_drainer.sv | 95 +++++++++
 tb/tb_store_row_drainer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/store_row_drainer.sv
// Row-buffered store path: each core fills its own lane of a DEPTH-row buffer,
// then rows 0..last_row are drained to data memory one full-width beat at a time.
module store_row_drainer #(
  parameter int NCORE   = 4,
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 16,
  parameter int MADDR_W = 16,
  localparam int RA_W   = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NCORE-1:0]          core_en,
  input  logic [NCORE-1:0]          st_req,
  input  logic [NCORE-1:0]          reg_wr,
  input  logic [NCORE*RA_W-1:0]     reg_addr,
  input  logic [NCORE*DATA_W-1:0]   reg_wdata,
  input  logic [MADDR_W-1:0]        base_addr,
  input  logic [RA_W-1:0]           last_row,
  output logic                      mem_valid,
  input  logic                      mem_ready,
  output logic [MADDR_W-1:0]        mem_addr,
  output logic [NCORE*DATA_W-1:0]   mem_wdata,
  output logic                      busy,
  output logic                      done,
  output logic [NCORE-1:0]          st_ack
);

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

  state_t                         state;
  logic [NCORE-1:0][DATA_W-1:0]   row_mem [DEPTH];
  logic [RA_W-1:0]                row;
  logic [RA_W-1:0]                last_q;
  logic [NCORE-1:0]               en_q;
  logic [MADDR_W-1:0]             base_q;
  logic                           start;

  assign start = (core_en != '0) && ((st_req & core_en) == core_en);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      row    <= '0;
      last_q <= '0;
      en_q   <= '0;
      base_q <= '0;
      for (int d = 0; d < DEPTH; d++) row_mem[d] <= '0;
    end else begin
      // Writes are frozen during DRAIN so the drained snapshot cannot change.
      if (state != DRAIN) begin
        for (int i = 0; i < NCORE; i++) begin
          if (reg_wr[i])
            row_mem[reg_addr[i*RA_W +: RA_W]][i] <= reg_wdata[i*DATA_W +: DATA_W];
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            en_q   <= core_en;
            base_q <= base_addr;
            last_q <= last_row;
            row    <= '0;
            state  <= DRAIN;
          end
        end
        DRAIN: begin
          if (mem_ready) begin
            if (row == last_q) state <= DONE;
            else               row   <= row + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode only registered state, so they are stable across ready-low stalls.
  assign mem_valid = (state == DRAIN);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign st_ack    = done ? en_q : '0;
  assign mem_addr  = mem_valid ? (base_q + MADDR_W'(row)) : '0;

  always_comb begin
    mem_wdata = '0;
    if (mem_valid) begin
      for (int i = 0; i < NCORE; i++) begin
        if (en_q[i]) mem_wdata[i*DATA_W +: DATA_W] = row_mem[row][i];
      end
    end
  end

endmodule

// File: tb/tb_store_row_drainer.sv
// Directed bench for store_row_drainer: table-driven drain vectors plus
// hand-written sequences for full drain, reset and reset-mid-drain.
module tb_store_row_drainer;
  localparam int NCORE = 4, DATA_W = 16, DEPTH = 16, MADDR_W = 16, RA_W = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NCORE-1:0]        core_en, st_req, reg_wr;
  logic [NCORE*RA_W-1:0]   reg_addr;
  logic [NCORE*DATA_W-1:0] reg_wdata;
  logic [MADDR_W-1:0]      base_addr;
  logic [RA_W-1:0]         last_row;
  logic                    mem_valid, mem_ready;
  logic [MADDR_W-1:0]      mem_addr;
  logic [NCORE*DATA_W-1:0] mem_wdata;
  logic                    busy, done;
  logic [NCORE-1:0]        st_ack;

  always #5 clk = ~clk;

  store_row_drainer #(.NCORE(NCORE), .DATA_W(DATA_W), .DEPTH(DEPTH), .MADDR_W(MADDR_W)) dut (
    .clk(clk), .rst(rst), .core_en(core_en), .st_req(st_req), .reg_wr(reg_wr),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .base_addr(base_addr), .last_row(last_row),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .st_ack(st_ack)
  );

  typedef struct {
    string       name;
    logic [3:0]  wr;
    logic [15:0] waddr;
    logic [63:0] wdata;
    logic [3:0]  req;
    logic [3:0]  en;
    logic [15:0] base;
    logic [3:0]  last;
    logic        ready;
    logic        e_valid;
    logic [15:0] e_addr;
    logic [63:0] e_wdata;
    logic        e_busy;
    logic        e_done;
    logic [3:0]  e_ack;
  } vec_t;

  int tests = 0;
  int fails = 0;
  logic [63:0] model [DEPTH];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string name, input logic v, input logic [15:0] a,
                          input logic [63:0] d, input logic b, input logic dn, input logic [3:0] ack);
    chk({name, ".valid"}, 64'(mem_valid), 64'(v));
    chk({name, ".addr"},  64'(mem_addr),  64'(a));
    chk({name, ".wdata"}, mem_wdata,      d);
    chk({name, ".busy"},  64'(busy),      64'(b));
    chk({name, ".done"},  64'(done),      64'(dn));
    chk({name, ".ack"},   64'(st_ack),    64'(ack));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    core_en = '0; st_req = '0; reg_wr = '0; reg_addr = '0; reg_wdata = '0;
    base_addr = '0; last_row = '0; mem_ready = 1'b1;
  endtask

  function automatic vec_t mk(string name, logic [3:0] wr, logic [15:0] waddr, logic [63:0] wdata,
                              logic [3:0] req, logic [3:0] en, logic [15:0] base, logic [3:0] last,
                              logic ready, logic e_valid, logic [15:0] e_addr, logic [63:0] e_wdata,
                              logic e_busy, logic e_done, logic [3:0] e_ack);
    vec_t v;
    v.name = name; v.wr = wr; v.waddr = waddr; v.wdata = wdata; v.req = req; v.en = en;
    v.base = base; v.last = last; v.ready = ready; v.e_valid = e_valid; v.e_addr = e_addr;
    v.e_wdata = e_wdata; v.e_busy = e_busy; v.e_done = e_done; v.e_ack = e_ack;
    return v;
  endfunction

  initial begin
    vec_t vecs[$];
    int beats, bad;
    logic got_done;

    vecs.push_back(mk("mask.start",  4'h0, 16'h0000, 64'h0, 4'h5, 4'h5, 16'h2000, 4'd2, 1'b1,
                      1'b1, 16'h2000, 64'h0000_0200_0000_0000, 1'b1, 1'b0, 4'h0));
    vecs.push_back(mk("mask.stall0", 4'h1, 16'h0001, 64'h0000_0000_0000_BEEF, 4'h0, 4'h5, 16'h2000, 4'd2, 1'b0,
                      1'b1, 16'h2000, 64'h0000_0200_0000_0000, 1'b1, 1'b0, 4'h0));
    vecs.push_back(mk("mask.row1",   4'h0, 16'h0000, 64'h0, 4'h0, 4'hF, 16'h7777, 4'd9, 1'b1,
                      1'b1, 16'h2001, 64'h0000_0201_0000_0001, 1'b1, 1'b0, 4'h0));
    vecs.push_back(mk("mask.stall1", 4'h0, 16'h0000, 64'h0, 4'h0, 4'hF, 16'h7777, 4'd9, 1'b0,
                      1'b1, 16'h2001, 64'h0000_0201_0000_0001, 1'b1, 1'b0, 4'h0));
    vecs.push_back(mk("mask.row2",   4'h0, 16'h0000, 64'h0, 4'h0, 4'h5, 16'h2000, 4'd2, 1'b1,
                      1'b1, 16'h2002, 64'h0000_0202_0000_0002, 1'b1, 1'b0, 4'h0));
    vecs.push_back(mk("mask.stall2", 4'h0, 16'h0000, 64'h0, 4'h0, 4'h5, 16'h2000, 4'd2, 1'b0,
                      1'b1, 16'h2002, 64'h0000_0202_0000_0002, 1'b1, 1'b0, 4'h0));
    vecs.push_back(mk("mask.done",   4'h0, 16'h0000, 64'h0, 4'h0, 4'h5, 16'h2000, 4'd2, 1'b1,
                      1'b0, 16'h0000, 64'h0, 1'b1, 1'b1, 4'h5));
    vecs.push_back(mk("mask.idle",   4'h0, 16'h0000, 64'h0, 4'h0, 4'h0, 16'h0000, 4'd0, 1'b1,
                      1'b0, 16'h0000, 64'h0, 1'b0, 1'b0, 4'h0));
    vecs.push_back(mk("wrap.start",  4'h4, 16'h0000, 64'h0000_A5A5_0000_0000, 4'hF, 4'hF, 16'hFFFF, 4'd1, 1'b1,
                      1'b1, 16'hFFFF, 64'h0300_A5A5_0100_0000, 1'b1, 1'b0, 4'h0));
    vecs.push_back(mk("wrap.row1",   4'h0, 16'h0000, 64'h0, 4'h0, 4'hF, 16'hFFFF, 4'd1, 1'b1,
                      1'b1, 16'h0000, 64'h0301_0201_0101_0001, 1'b1, 1'b0, 4'h0));
    vecs.push_back(mk("wrap.done",   4'h0, 16'h0000, 64'h0, 4'hF, 4'hF, 16'h3000, 4'd0, 1'b1,
                      1'b0, 16'h0000, 64'h0, 1'b1, 1'b1, 4'hF));
    vecs.push_back(mk("hold.idle",   4'h0, 16'h0000, 64'h0, 4'hF, 4'hF, 16'h3000, 4'd0, 1'b1,
                      1'b0, 16'h0000, 64'h0, 1'b0, 1'b0, 4'h0));
    vecs.push_back(mk("hold.start",  4'h0, 16'h0000, 64'h0, 4'hF, 4'hF, 16'h3000, 4'd0, 1'b1,
                      1'b1, 16'h3000, 64'h0300_A5A5_0100_0000, 1'b1, 1'b0, 4'h0));
    vecs.push_back(mk("hold.done",   4'h0, 16'h0000, 64'h0, 4'h0, 4'h0, 16'h0000, 4'd0, 1'b1,
                      1'b0, 16'h0000, 64'h0, 1'b1, 1'b1, 4'hF));
    vecs.push_back(mk("hold.idle2",  4'h0, 16'h0000, 64'h0, 4'h0, 4'h0, 16'h0000, 4'd0, 1'b1,
                      1'b0, 16'h0000, 64'h0, 1'b0, 1'b0, 4'h0));

    // Reset then idle
    idle_inputs();
    rst = 1'b1;
    repeat (3) tick();
    chk_outs("reset", 1'b0, 16'h0, 64'h0, 1'b0, 1'b0, 4'h0);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk_outs("idle", 1'b0, 16'h0, 64'h0, 1'b0, 1'b0, 4'h0);
    end

    // Fill every row: core i writes {i, row} into its own lane
    for (int r = 0; r < DEPTH; r++) begin
      reg_wr = 4'hF;
      for (int i = 0; i < NCORE; i++) begin
        reg_addr[i*RA_W +: RA_W]       = RA_W'(r);
        reg_wdata[i*DATA_W +: DATA_W]  = {8'(i), 8'(r)};
        model[r][i*DATA_W +: DATA_W]   = {8'(i), 8'(r)};
      end
      tick();
    end
    idle_inputs();

    // Full 16-row drain with ready tied high
    core_en = 4'hF; st_req = 4'hF; base_addr = 16'h1000; last_row = 4'd15;
    tick();
    st_req = 4'h0;
    for (int k = 0; k < DEPTH; k++) begin
      chk_outs($sformatf("full.beat%0d", k), 1'b1, 16'h1000 + 16'(k), model[k], 1'b1, 1'b0, 4'h0);
      tick();
    end
    chk_outs("full.done", 1'b0, 16'h0, 64'h0, 1'b1, 1'b1, 4'hF);
    tick();
    chk_outs("full.idle", 1'b0, 16'h0, 64'h0, 1'b0, 1'b0, 4'h0);

    // Table: masked lanes, back-pressure, blocked write, same-cycle write+start, wrap, held st_req
    for (int n = 0; n < vecs.size(); n++) begin
      reg_wr = vecs[n].wr; reg_addr = vecs[n].waddr; reg_wdata = vecs[n].wdata;
      st_req = vecs[n].req; core_en = vecs[n].en; base_addr = vecs[n].base;
      last_row = vecs[n].last; mem_ready = vecs[n].ready;
      tick();
      chk_outs(vecs[n].name, vecs[n].e_valid, vecs[n].e_addr, vecs[n].e_wdata,
               vecs[n].e_busy, vecs[n].e_done, vecs[n].e_ack);
    end
    idle_inputs();

    // Reset during beat 5 of a 16-row drain
    core_en = 4'hF; st_req = 4'hF; base_addr = 16'h1000; last_row = 4'd15;
    tick();
    st_req = 4'h0;
    repeat (5) tick();
    chk("rstmid.beat5_addr", 64'(mem_addr), 64'h1005);
    rst = 1'b1;
    tick();
    chk_outs("rstmid.reset", 1'b0, 16'h0, 64'h0, 1'b0, 1'b0, 4'h0);
    rst = 1'b0;
    tick();
    chk_outs("rstmid.after", 1'b0, 16'h0, 64'h0, 1'b0, 1'b0, 4'h0);

    // Fresh drain starts from row 0; the buffer was cleared by reset
    last_row = 4'd3; st_req = 4'hF;
    tick();
    st_req = 4'h0;
    chk_outs("restart.row0", 1'b1, 16'h1000, 64'h0, 1'b1, 1'b0, 4'h0);
    beats = 0; bad = 0; got_done = 1'b0;
    for (int c = 0; c < 20 && !got_done; c++) begin
      if (mem_valid) begin
        if (mem_wdata !== 64'h0 || mem_addr !== 16'h1000 + 16'(beats)) bad++;
        beats++;
      end
      if (done) got_done = 1'b1;
      else tick();
    end
    chk("restart.done_seen", 64'(got_done), 64'h1);
    chk("restart.beats", 64'(beats), 64'd4);
    chk("restart.beat_content", 64'(bad), 64'd0);
    chk("restart.ack", 64'(st_ack), 64'hF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
